alu_cmd_sequencer: RTL and testbench

//  Initiator side of the alu_32 operand/result interface: accepts ALU commands on a valid/ready

---
 rtl/alu_cmd_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Initiator side of the alu_32 operand/result interface. Takes one
//            ALU command at a time from a valid/ready stream, drives the
//            registered operands into the combinational ALU, waits a fixed
//            settle time, captures result and flags, and returns them on a
//            valid/ready response stream with a wrapping sequence tag.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   cmd_valid_i    command present
//   cmd_ready_o    sequencer idle; command accepted on valid & ready
//   cmd_a_i        operand A
//   cmd_b_i        operand B
//   cmd_sel_i      ALU operation select
//   alu_a_o        registered operand A to alu_32
//   alu_b_o        registered operand B to alu_32
//   alu_sel_o      registered select to alu_32
//   alu_out_i      alu_32 result
//   alu_carry_i    alu_32 carry out
//   alu_zero_i     alu_32 zero flag
//   alu_ovf_i      alu_32 overflow flag
//   rsp_valid_o    response present
//   rsp_ready_i    response consumer ready
//   rsp_result_o   captured ALU result
//   rsp_flags_o    captured {ovf, carry, zero}
//   rsp_tag_o      sequence number of this response
//   stat_clr_i     synchronous clear of the statistics counters
//   stat_ops_o     completed responses (saturating)
//   stat_ovf_o     completed responses with ovf set (saturating)
// Build option
//   ALU_STATS_EN   defined: statistics counters present.
//                  undefined: stat_* tied to zero, stat_clr_i ignored.
// ============================================================================
module alu_cmd_sequencer #(
  parameter int DATA_W        = 32,
  parameter int SEL_W         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int TAG_W         = 4,
  parameter int CNT_W         = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_a_i,
  input  logic [DATA_W-1:0] cmd_b_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [SEL_W-1:0]  alu_sel_o,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic              alu_carry_i,
  input  logic              alu_zero_i,
  input  logic              alu_ovf_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic [2:0]        rsp_flags_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  input  logic              stat_clr_i,
  output logic [CNT_W-1:0]  stat_ops_o,
  output logic [CNT_W-1:0]  stat_ovf_o
);

  // The settle counter only ever holds SETTLE_CYCLES-1 down to 0.
  localparam int SETTLE_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("alu_cmd_sequencer: SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [SETTLE_CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [DATA_W-1:0]       alu_a_q, alu_a_d;
  logic [DATA_W-1:0]       alu_b_q, alu_b_d;
  logic [SEL_W-1:0]        alu_sel_q, alu_sel_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_result_q, rsp_result_d;
  logic [2:0]              rsp_flags_q, rsp_flags_d;
  logic [TAG_W-1:0]        rsp_tag_q, rsp_tag_d;
  logic [TAG_W-1:0]        tag_cnt_q, tag_cnt_d;
  logic                    w_rsp_hs;

  assign w_rsp_hs = rsp_valid_q & rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_tag_q    <= '0;
      tag_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_tag_q    <= rsp_tag_d;
      tag_cnt_q    <= tag_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_tag_d    = rsp_tag_q;
    tag_cnt_d    = tag_cnt_q;

    case (state_q)
      IDLE: begin
        // cmd_ready is high throughout IDLE, so valid alone is the handshake.
        if (cmd_valid_i) begin
          alu_a_d      = cmd_a_i;
          alu_b_d      = cmd_b_i;
          alu_sel_d    = cmd_sel_i;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_q == '0) begin
          rsp_result_d = alu_out_i;
          rsp_flags_d  = {alu_ovf_i, alu_carry_i, alu_zero_i};
          rsp_tag_d    = tag_cnt_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_CNT_W'(1);
        end
      end
      RESP: begin
        // Operands are left in place after the response so the ALU inputs
        // do not toggle needlessly.
        if (w_rsp_hs) begin
          rsp_valid_d = 1'b0;
          tag_cnt_d   = tag_cnt_q + TAG_W'(1);
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_sel_o    = alu_sel_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_flags_o  = rsp_flags_q;
  assign rsp_tag_o    = rsp_tag_q;

`ifdef ALU_STATS_EN
  logic [CNT_W-1:0] stat_ops_q;
  logic [CNT_W-1:0] stat_ovf_q;

  // Clear wins over a same-cycle handshake; both counters stick at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else if (stat_clr_i) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else if (w_rsp_hs) begin
      if (!(&stat_ops_q)) begin
        stat_ops_q <= stat_ops_q + CNT_W'(1);
      end
      if (rsp_flags_q[2] && !(&stat_ovf_q)) begin
        stat_ovf_q <= stat_ovf_q + CNT_W'(1);
      end
    end
  end

  assign stat_ops_o = stat_ops_q;
  assign stat_ovf_o = stat_ovf_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_ops_o      = '0;
  assign stat_ovf_o      = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Purpose  : Self-checking bench for alu_cmd_sequencer. Two instances share
//            clock, reset, command data and rsp_ready: dut1 settles in one
//            cycle, dut3 in three. A behavioural alu_32 model feeds each.
//            Build option ALU_STATS_EN selects the statistics checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  localparam int CNT_W = 2;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid1, cmd_valid3;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_sel;
  logic        rsp_ready;
  logic        stat_clr;
  logic        dsel;

  logic        cmd_ready1, rsp_valid1, alu_carry1, alu_zero1, alu_ovf1;
  logic [31:0] alu_a1, alu_b1, alu_out1, rsp_result1;
  logic [3:0]  alu_sel1, rsp_tag1;
  logic [2:0]  rsp_flags1;
  logic [CNT_W-1:0] stat_ops1, stat_ovf1;

  logic        cmd_ready3, rsp_valid3, alu_carry3, alu_zero3, alu_ovf3;
  logic [31:0] alu_a3, alu_b3, alu_out3, rsp_result3;
  logic [3:0]  alu_sel3, rsp_tag3;
  logic [2:0]  rsp_flags3;
  logic [CNT_W-1:0] stat_ops3, stat_ovf3;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural alu_32: add, sub, and, or, xor. Returns {ovf, carry, zero, result}.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
    logic [32:0] w;
    logic [31:0] r;
    logic        c, v;
    w = '0; r = '0; c = 1'b0; v = 1'b0;
    case (s)
      4'h0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'h1: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      default: r = '0;
    endcase
    return {v, c, (r == 32'h0), r};
  endfunction

  assign {alu_ovf1, alu_carry1, alu_zero1, alu_out1} = alu_model(alu_a1, alu_b1, alu_sel1);
  assign {alu_ovf3, alu_carry3, alu_zero3, alu_out3} = alu_model(alu_a3, alu_b3, alu_sel3);

  alu_cmd_sequencer #(.DATA_W(32), .SEL_W(4), .SETTLE_CYCLES(1), .TAG_W(4), .CNT_W(CNT_W)) dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid1), .cmd_ready_o(cmd_ready1),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_sel_i(cmd_sel),
    .alu_a_o(alu_a1), .alu_b_o(alu_b1), .alu_sel_o(alu_sel1),
    .alu_out_i(alu_out1), .alu_carry_i(alu_carry1), .alu_zero_i(alu_zero1), .alu_ovf_i(alu_ovf1),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result1), .rsp_flags_o(rsp_flags1), .rsp_tag_o(rsp_tag1),
    .stat_clr_i(stat_clr), .stat_ops_o(stat_ops1), .stat_ovf_o(stat_ovf1)
  );

  alu_cmd_sequencer #(.DATA_W(32), .SEL_W(4), .SETTLE_CYCLES(3), .TAG_W(4), .CNT_W(CNT_W)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid3), .cmd_ready_o(cmd_ready3),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_sel_i(cmd_sel),
    .alu_a_o(alu_a3), .alu_b_o(alu_b3), .alu_sel_o(alu_sel3),
    .alu_out_i(alu_out3), .alu_carry_i(alu_carry3), .alu_zero_i(alu_zero3), .alu_ovf_i(alu_ovf3),
    .rsp_valid_o(rsp_valid3), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result3), .rsp_flags_o(rsp_flags3), .rsp_tag_o(rsp_tag3),
    .stat_clr_i(stat_clr), .stat_ops_o(stat_ops3), .stat_ovf_o(stat_ovf3)
  );

  // View of whichever instance is currently under test.
  logic        w_cmd_ready, w_rsp_valid;
  logic [31:0] w_rsp_result, w_alu_a, w_alu_b;
  logic [3:0]  w_alu_sel, w_rsp_tag;
  logic [2:0]  w_rsp_flags;
  assign w_cmd_ready  = dsel ? cmd_ready3  : cmd_ready1;
  assign w_rsp_valid  = dsel ? rsp_valid3  : rsp_valid1;
  assign w_rsp_result = dsel ? rsp_result3 : rsp_result1;
  assign w_rsp_flags  = dsel ? rsp_flags3  : rsp_flags1;
  assign w_rsp_tag    = dsel ? rsp_tag3    : rsp_tag1;
  assign w_alu_a      = dsel ? alu_a3      : alu_a1;
  assign w_alu_b      = dsel ? alu_b3      : alu_b1;
  assign w_alu_sel    = dsel ? alu_sel3    : alu_sel1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [31:0] res;
    logic [2:0]  flags;   // {ovf, carry, zero}
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_valid(input logic v);
    if (dsel) cmd_valid3 = v;
    else      cmd_valid1 = v;
  endtask

  // Present a command and return #1 after the edge that accepts it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    logic ok;
    ok = 1'b0;
    cmd_a = a; cmd_b = b; cmd_sel = s;
    set_valid(1'b1);
    for (int k = 0; k < 64; k++) begin
      if (w_cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    set_valid(1'b0);
  endtask

  // Count edges from the accept point until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!w_rsp_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!w_rsp_valid) check("rsp_timeout", 0, 1);
  endtask

  int  lat;
  int  tag1;
  logic seen;

  initial begin
    vecs[0] = '{32'h086a0c31, 32'hd785f148, 4'h0, 32'hdfeffd79, 3'b000};
    vecs[1] = '{32'hffffffff, 32'h00000001, 4'h0, 32'h00000000, 3'b011};
    vecs[2] = '{32'h7fffffff, 32'h00000001, 4'h0, 32'h80000000, 3'b100};
    vecs[3] = '{32'h80000000, 32'h80000000, 4'h0, 32'h00000000, 3'b111};
    vecs[4] = '{32'h00000005, 32'h00000003, 4'h1, 32'h00000002, 3'b000};
    vecs[5] = '{32'h00000003, 32'h00000005, 4'h1, 32'hfffffffe, 3'b010};
    vecs[6] = '{32'h80000000, 32'h00000001, 4'h1, 32'h7fffffff, 3'b100};
    vecs[7] = '{32'hf0f0f0f0, 32'h0f0f0f0f, 4'h8, 32'h00000000, 3'b001};
    vecs[8] = '{32'h12340000, 32'h00005678, 4'h9, 32'h12345678, 3'b000};
    vecs[9] = '{32'ha5a5a5a5, 32'hffffffff, 4'hA, 32'h5a5a5a5a, 3'b000};

    rst_n = 1'b0; cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0; rsp_ready = 1'b1; stat_clr = 1'b0; dsel = 1'b0;
    tag1 = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready1, 1);
    check("rst_rsp_valid", rsp_valid1, 0);
    check("rst_alu_a", alu_a1, 0);
    check("rst_rsp_result", rsp_result1, 0);
    check("rst_rsp_tag", rsp_tag1, 0);
    check("rst_stat_ops", stat_ops1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven commands on the single-cycle-settle instance
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].sel);
      check($sformatf("v%0d_alu_a", i), w_alu_a, vecs[i].a);
      check($sformatf("v%0d_alu_b", i), w_alu_b, vecs[i].b);
      check($sformatf("v%0d_alu_sel", i), w_alu_sel, vecs[i].sel);
      check($sformatf("v%0d_busy", i), w_cmd_ready, 0);
      wait_rsp(lat);
      check($sformatf("v%0d_latency", i), lat, 1);
      check($sformatf("v%0d_result", i), w_rsp_result, vecs[i].res);
      check($sformatf("v%0d_flags", i), w_rsp_flags, vecs[i].flags);
      check($sformatf("v%0d_tag", i), w_rsp_tag, tag1);
      @(posedge clk); #1;
      tag1 = (tag1 + 1) % 16;
      check($sformatf("v%0d_rsp_done", i), w_rsp_valid, 0);
      check($sformatf("v%0d_ready_back", i), w_cmd_ready, 1);
      check($sformatf("v%0d_alu_a_hold", i), w_alu_a, vecs[i].a);
    end

    // Backpressure: response held, second command waits for the handshake
    rsp_ready = 1'b0;
    issue(32'h12345678, 32'h11111111, 4'h9);
    wait_rsp(lat);
    check("bp_latency", lat, 1);
    cmd_a = 32'hf0f0f0f0; cmd_b = 32'h0f0f0f0f; cmd_sel = 4'h8; cmd_valid1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_valid", k), w_rsp_valid, 1);
      check($sformatf("bp%0d_result", k), w_rsp_result, 32'h13355779);
      check($sformatf("bp%0d_tag", k), w_rsp_tag, tag1);
      check($sformatf("bp%0d_cmd_ready", k), w_cmd_ready, 0);
      check($sformatf("bp%0d_alu_sel", k), w_alu_sel, 4'h9);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tag1 = (tag1 + 1) % 16;
    check("bp_hs_valid", w_rsp_valid, 0);
    check("bp_hs_ready", w_cmd_ready, 1);
    check("bp_not_taken_yet", w_alu_sel, 4'h9);
    @(posedge clk); #1;
    cmd_valid1 = 1'b0;
    check("bp_second_taken", w_cmd_ready, 0);
    check("bp_second_alu_a", w_alu_a, 32'hf0f0f0f0);
    wait_rsp(lat);
    check("bp_second_result", w_rsp_result, 32'h00000000);
    check("bp_second_flags", w_rsp_flags, 3'b001);
    check("bp_second_tag", w_rsp_tag, tag1);
    @(posedge clk); #1;
    tag1 = (tag1 + 1) % 16;

`ifdef ALU_STATS_EN
    // Saturating statistics with CNT_W=2, then clear against a handshake
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    tag1 = 0;
    check("st_after_rst", stat_ops1, 0);
    for (int k = 0; k < 5; k++) begin
      issue(vecs[k].a, vecs[k].b, vecs[k].sel);
      wait_rsp(lat);
      @(posedge clk); #1;
      tag1 = (tag1 + 1) % 16;
      if (k == 0) check("st_ops_first", stat_ops1, 1);
      if (k == 2) check("st_ovf_first", stat_ovf1, 1);
    end
    check("st_ops_sat", stat_ops1, 3);
    check("st_ovf", stat_ovf1, 2);
    rsp_ready = 1'b0;
    issue(vecs[2].a, vecs[2].b, vecs[2].sel);
    wait_rsp(lat);
    stat_clr = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    tag1 = (tag1 + 1) % 16;
    check("st_clr_hs_valid", rsp_valid1, 0);
    check("st_clr_ops", stat_ops1, 0);
    check("st_clr_ovf", stat_ovf1, 0);
`else
    check("nostats_ops", stat_ops1, 0);
    check("nostats_ovf", stat_ovf1, 0);
`endif

    // Mid-cycle reset while a response is pending
    check("pre_rst_tag_nonzero", (tag1 != 0), 1);
    rsp_ready = 1'b0;
    issue(32'h80000000, 32'h00000001, 4'h1);
    wait_rsp(lat);
    check("pre_rst_valid", rsp_valid1, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid1, 0);
    check("mid_rst_result", rsp_result1, 0);
    check("mid_rst_flags", rsp_flags1, 0);
    check("mid_rst_tag", rsp_tag1, 0);
    check("mid_rst_alu_a", alu_a1, 0);
    check("mid_rst_alu_b", alu_b1, 0);
    check("mid_rst_alu_sel", alu_sel1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", cmd_ready1, 1);
    issue(vecs[8].a, vecs[8].b, vecs[8].sel);
    wait_rsp(lat);
    check("post_rst_tag", rsp_tag1, 0);
    check("post_rst_result", rsp_result1, vecs[8].res);
    @(posedge clk); #1;

    // Three-cycle settle: 17 back-to-back commands, tag wraps 15 -> 0
    dsel = 1'b1;
    for (int k = 0; k < 17; k++) begin
      issue(vecs[k % 10].a, vecs[k % 10].b, vecs[k % 10].sel);
      wait_rsp(lat);
      check($sformatf("s3_%0d_latency", k), lat, 3);
      check($sformatf("s3_%0d_tag", k), w_rsp_tag, k % 16);
      check($sformatf("s3_%0d_result", k), w_rsp_result, vecs[k % 10].res);
      check($sformatf("s3_%0d_flags", k), w_rsp_flags, vecs[k % 10].flags);
      @(posedge clk); #1;
    end

    // Reset pulse during SETTLE aborts the command
    issue(vecs[1].a, vecs[1].b, vecs[1].sel);
    @(posedge clk); #1;
    check("abort_in_settle", w_cmd_ready, 0);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("abort_ready", w_cmd_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (w_rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", seen, 0);
    check("abort_ready_held", w_cmd_ready, 1);
    issue(vecs[9].a, vecs[9].b, vecs[9].sel);
    wait_rsp(lat);
    check("abort_next_tag", w_rsp_tag, 0);
    check("abort_next_latency", lat, 3);
    check("abort_next_result", w_rsp_result, vecs[9].res);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
